// File: rtl/rotate_collision_checker_pkg.sv
// +----------------------------------------------------------------------------+
// | rotate_collision_checker_pkg: shared tile, shape and checker FSM types      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package rotate_collision_checker_pkg;

  localparam int unsigned PX_W = 4;
  localparam int unsigned PY_W = 5;

  typedef enum logic [2:0] {
    eNon = 3'd0,
    eI   = 3'd1,
    eO   = 3'd2,
    eT   = 3'd3,
    eS   = 3'd4,
    eZ   = 3'd5,
    eJ   = 3'd6,
    eL   = 3'd7
  } tile_type_e;

  typedef struct packed {
    logic [PX_W-1:0] x_m;
    logic [PY_W-1:0] y_m;
  } point_t;

  typedef struct packed {
    logic [1:0] dy;
    logic [1:0] dx;
  } cell_offset_t;

  typedef cell_offset_t [3:0] shape_t;

  typedef enum logic [2:0] {
    eIDLE  = 3'd0,
    eROM   = 3'd1,
    eCHECK = 3'd2,
    eDRAIN = 3'd3,
    eDONE  = 3'd4
  } checker_state_e;

  function automatic cell_offset_t shape_cell(input shape_t shape, input logic [1:0] k);
    return shape[k];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rotate_collision_checker_cell_addr.sv
// +----------------------------------------------------------------------------+
// | tile_cell_addr: base position + cell offset -> map address and bounds flag  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_cell_addr
  import rotate_collision_checker_pkg::*;
#(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32,
  localparam int unsigned XW = $clog2(width_p),
  localparam int unsigned YW = $clog2(height_p)
) (
  input  point_t       pos_i,
  input  cell_offset_t off_i,
  output logic [XW-1:0] ax_o,
  output logic [YW-1:0] ay_o,
  output logic         oob_o
);

  localparam logic [XW:0] X_LIM = (XW+1)'(width_p);
  localparam logic [YW:0] Y_LIM = (YW+1)'(height_p);

  // One extra bit so a sum past the map edge is seen as out of bounds, never wrapped.
  logic [XW:0] ax_w;
  logic [YW:0] ay_w;

  assign ax_w  = (XW+1)'(pos_i.x_m) + (XW+1)'(off_i.dx);
  assign ay_w  = (YW+1)'(pos_i.y_m) + (YW+1)'(off_i.dy);
  assign oob_o = (ax_w >= X_LIM) | (ay_w >= Y_LIM);
  assign ax_o  = ax_w[XW-1:0];
  assign ay_o  = ay_w[YW-1:0];

endmodule

`default_nettype wire

// File: rtl/rotate_collision_checker.sv
// +----------------------------------------------------------------------------+
// | rotate_collision_checker: checks whether the tile fits at angle+1           |
// | Optional: ROTATE_CHECK_EARLY_EXIT_EN stops at the first failing cell.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module rotate_collision_checker
  import rotate_collision_checker_pkg::*;
#(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32,
  localparam int unsigned XW = $clog2(width_p),
  localparam int unsigned YW = $clog2(height_p)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          v_i,
  output logic          ready_o,
  input  tile_type_e    type_i,
  input  logic [1:0]    angle_i,
  input  point_t        pos_i,
  output logic [4:0]    rom_addr_o,
  input  logic [15:0]   rom_data_i,
  output logic          mm_r_v_o,
  output logic [XW-1:0] mm_addr_x_o,
  output logic [YW-1:0] mm_addr_y_o,
  input  logic          mm_data_i,
  output logic          done_v_o,
  output logic          avail_o
);

  checker_state_e state_q, state_d;
  tile_type_e     type_q, type_d;
  logic [1:0]     angle_q, angle_d;
  point_t         pos_q, pos_d;
  logic [1:0]     k_q, k_d;
  logic           fail_q, fail_d;
  logic           rd_pend_q, rd_pend_d;
  logic           oob_pend_q, oob_pend_d;
  logic           avail_q, avail_d;

  cell_offset_t   cell_w;
  logic           oob_w;
  logic           hit_w;

  assign cell_w = shape_cell(shape_t'(rom_data_i), k_q);

  tile_cell_addr #(
    .width_p  (width_p),
    .height_p (height_p)
  ) u_cell_addr (
    .pos_i (pos_q),
    .off_i (cell_w),
    .ax_o  (mm_addr_x_o),
    .ay_o  (mm_addr_y_o),
    .oob_o (oob_w)
  );

  // An out-of-bounds cell never issues a read, so its stale map data is ignored.
  assign hit_w = oob_pend_q | (rd_pend_q & mm_data_i);

  assign ready_o    = (state_q == eIDLE);
  assign done_v_o   = (state_q == eDONE);
  assign avail_o    = avail_q;
  assign rom_addr_o = {type_q, angle_q};
  assign mm_r_v_o   = (state_q == eCHECK) & ~oob_w;

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    angle_d    = angle_q;
    pos_d      = pos_q;
    k_d        = k_q;
    fail_d     = fail_q | hit_w;
    rd_pend_d  = 1'b0;
    oob_pend_d = 1'b0;
    avail_d    = avail_q;
    case (state_q)
      eIDLE: begin
        if (v_i) begin
          type_d  = type_i;
          pos_d   = pos_i;
          angle_d = angle_i + 2'd1;
          fail_d  = 1'b0;
          avail_d = 1'b0;
          k_d     = 2'd0;
          state_d = eROM;
        end
      end
      eROM: begin
        k_d = 2'd0;
        if (type_q == eNon) begin
          avail_d = 1'b0;
          state_d = eDONE;
        end else begin
          state_d = eCHECK;
        end
      end
      eCHECK: begin
        rd_pend_d  = ~oob_w;
        oob_pend_d = oob_w;
        k_d        = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = eDRAIN;
        end
`ifdef ROTATE_CHECK_EARLY_EXIT_EN
        if (hit_w) begin
          rd_pend_d  = 1'b0;
          oob_pend_d = 1'b0;
          avail_d    = 1'b0;
          state_d    = eDONE;
        end
`endif
      end
      eDRAIN: begin
        avail_d = ~(fail_q | hit_w);
        state_d = eDONE;
      end
      eDONE: begin
        state_d = eIDLE;
      end
      default: begin
        state_d = eIDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= eIDLE;
      type_q     <= eNon;
      angle_q    <= 2'd0;
      pos_q      <= '0;
      k_q        <= 2'd0;
      fail_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      oob_pend_q <= 1'b0;
      avail_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      angle_q    <= angle_d;
      pos_q      <= pos_d;
      k_q        <= k_d;
      fail_q     <= fail_d;
      rd_pend_q  <= rd_pend_d;
      oob_pend_q <= oob_pend_d;
      avail_q    <= avail_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rotate_collision_checker.sv
// +----------------------------------------------------------------------------+
// | tb_rotate_collision_checker: directed bench with ROM and map memory models  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rotate_collision_checker;
  import rotate_collision_checker_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        v_i;
  logic        ready_o;
  tile_type_e  type_i;
  logic [1:0]  angle_i;
  point_t      pos_i;
  logic [4:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        mm_r_v_o;
  logic [3:0]  mm_addr_x_o;
  logic [4:0]  mm_addr_y_o;
  logic        mm_data_i;
  logic        done_v_o;
  logic        avail_o;

  int total = 0;
  int bad   = 0;

  logic       map_q [0:31][0:15];
  logic [3:0] ax_log [0:15];
  logic [4:0] ay_log [0:15];

  always #5 clk = ~clk;

  rotate_collision_checker dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .v_i         (v_i),
    .ready_o     (ready_o),
    .type_i      (type_i),
    .angle_i     (angle_i),
    .pos_i       (pos_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .mm_r_v_o    (mm_r_v_o),
    .mm_addr_x_o (mm_addr_x_o),
    .mm_addr_y_o (mm_addr_y_o),
    .mm_data_i   (mm_data_i),
    .done_v_o    (done_v_o),
    .avail_o     (avail_o)
  );

  // Shapes as {c3,c2,c1,c0}, cell = {dy,dx}.
  // T: (1,0) (0,1) (1,1) (1,2); I: (0..3, 1); others: 2x2 block.
  function automatic logic [15:0] rom_fn(input logic [4:0] a);
    logic [2:0] t;
    t = a[4:2];
    if (t == 3'(eT)) return 16'h9541;
    if (t == 3'(eI)) return 16'h7654;
    return 16'h5410;
  endfunction

  always @(posedge clk) begin
    rom_data_i <= rom_fn(rom_addr_o);
    // Deliberately 1 when no read was issued: unread cells must not count.
    mm_data_i  <= mm_r_v_o ? map_q[mm_addr_y_o][mm_addr_x_o] : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input tile_type_e t, input logic [1:0] ang,
                        input logic [3:0] x, input logic [4:0] y, input int exp_done,
                        input logic exp_avail, input logic [15:0] exp_rmask,
                        input logic [4:0] exp_rom);
    int          done_cyc;
    logic        av;
    logic [15:0] rmask;
    logic [4:0]  rom1;
    done_cyc = -1;
    av       = 1'b0;
    rmask    = '0;
    rom1     = '0;
    type_i   = t;
    angle_i  = ang;
    pos_i    = '{x_m: x, y_m: y};
    v_i      = 1'b1;
    chk({tag, " ready"}, 32'(ready_o), 32'd1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      v_i = 1'b0;
      if (c == 1) rom1 = rom_addr_o;
      if (mm_r_v_o) begin
        rmask[c]  = 1'b1;
        ax_log[c] = mm_addr_x_o;
        ay_log[c] = mm_addr_y_o;
      end
      if (done_v_o && done_cyc < 0) begin
        done_cyc = c;
        av       = avail_o;
      end
    end
    chk({tag, " rom_addr"}, 32'(rom1), 32'(exp_rom));
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, " avail"}, 32'(av), 32'(exp_avail));
    chk({tag, " avail_held"}, 32'(avail_o), 32'(exp_avail));
    chk({tag, " read_cycles"}, 32'(rmask), 32'(exp_rmask));
  endtask

  initial begin
    logic        seen;
    logic [31:0] rdy_mask;
    logic [31:0] done_mask;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 16; xx++)
        map_q[yy][xx] = 1'b0;
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    type_i    = eNon;
    angle_i   = 2'd0;
    pos_i     = '0;
    #1;
    chk("rst ready", 32'(ready_o), 32'd1);
    chk("rst done", 32'(done_v_o), 32'd0);
    chk("rst mm_r_v", 32'(mm_r_v_o), 32'd0);
    chk("rst avail", 32'(avail_o), 32'd0);
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();

    run_op("t_empty", eT, 2'd0, 4'd5, 5'd10, 7, 1'b1, 16'h003C, {eT, 2'd1});
    chk("t_empty addr0", {ay_log[2], ax_log[2]}, {5'd10, 4'd6});
    chk("t_empty addr2", {ay_log[4], ax_log[4]}, {5'd11, 4'd6});
    chk("t_empty addr3", {ay_log[5], ax_log[5]}, {5'd12, 4'd6});

    map_q[11][6] = 1'b1;
    run_op("t_occ", eT, 2'd0, 4'd5, 5'd10, 7, 1'b0, 16'h003C, {eT, 2'd1});
    map_q[11][6] = 1'b0;

    run_op("i_oob", eI, 2'd1, 4'd14, 5'd3, 7, 1'b0, 16'h000C, {eI, 2'd2});
    run_op("i_edge", eI, 2'd2, 4'd12, 5'd3, 7, 1'b1, 16'h003C, {eI, 2'd3});
    run_op("t_bottom", eT, 2'd3, 4'd0, 5'd30, 7, 1'b0, 16'h001C, {eT, 2'd0});
    run_op("non", eNon, 2'd0, 4'd3, 5'd3, 2, 1'b0, 16'h0000, {eNon, 2'd1});

    // Reset asserted in cycle 4 of an operation.
    type_i  = eT;
    angle_i = 2'd0;
    pos_i   = '{x_m: 4'd5, y_m: 5'd10};
    v_i     = 1'b1;
    tick();
    v_i = 1'b0;
    tick();
    tick();
    tick();
    reset_n_i = 1'b0;
    #1;
    chk("midrst ready", 32'(ready_o), 32'd1);
    chk("midrst mm_r_v", 32'(mm_r_v_o), 32'd0);
    chk("midrst avail", 32'(avail_o), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_v_o) seen = 1'b1;
    end
    chk("midrst no_done", 32'(seen), 32'd0);
    reset_n_i = 1'b1;
    tick();
    run_op("after_rst", eT, 2'd0, 4'd5, 5'd10, 7, 1'b1, 16'h003C, {eT, 2'd1});

    // Continuous request stream.
    rdy_mask  = '0;
    done_mask = '0;
    v_i = 1'b1;
    for (int c = 0; c < 18; c++) begin
      rdy_mask[c]  = ready_o;
      done_mask[c] = done_v_o;
      tick();
    end
    v_i = 1'b0;
    chk("b2b ready_cycles", rdy_mask, 32'h0001_0101);
    chk("b2b done_cycles", done_mask, 32'h0000_8080);
    for (int c = 0; c < 10; c++) tick();
    chk("b2b final_idle", 32'(ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
